// File: rtl/ide_pio_seq.sv
// IDE PIO cycle sequencer: chip-select setup, timed IOR_n/IOW_n strobe, dtack handshake, recovery.
// Define IDE_IORDY_EN to honour IORDY wait extension (synchroniser, WAIT_RDY, rdy_timeout).
module ide_pio_seq #(
    parameter int T_SETUP     = 2,
    parameter int T_ACTIVE    = 9,
    parameter int T_RECOVER   = 3,
    parameter int RDY_TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RESET,
    input  logic start,
    input  logic cs_sel,
    input  logic RW,
    input  logic AS_n,
    input  logic IORDY,
    output logic IOR_n,
    output logic IOW_n,
    output logic IDECS1_n,
    output logic IDECS2_n,
    output logic dtack,
    output logic busy,
    output logic rdy_timeout
);

    typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, WAIT_RDY, ACK, RECOVER} state_t;

    localparam logic [3:0] PH_SETUP = 4'(T_SETUP - 1);
    localparam logic [3:0] PH_ACT   = 4'(T_ACTIVE - 1);
    localparam logic [3:0] PH_REC   = 4'(T_RECOVER - 1);

    state_t     state_q, state_d;
    logic [3:0] ph_q, ph_d;
    logic [7:0] tmo_q, tmo_d;
    logic       rw_q, rw_d, sel_q, sel_d;
    logic       tflag_q, tflag_d;
    logic       rdy_s;
    logic       cs_on, stb_on;

`ifdef IDE_IORDY_EN
    localparam logic [7:0] TMO_LAST = 8'(RDY_TIMEOUT - 1);
    logic [1:0] sync_q;

    always_ff @(posedge CLK) begin
        if (RESET) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], IORDY};
    end
    assign rdy_s       = sync_q[1];
    assign rdy_timeout = tflag_q;
`else
    logic [18:0] unused_cfg;
    assign unused_cfg  = {IORDY, tflag_q, tmo_q, 9'(RDY_TIMEOUT)};
    assign rdy_s       = 1'b1;
    assign rdy_timeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            ph_q    <= '0;
            tmo_q   <= '0;
            rw_q    <= 1'b0;
            sel_q   <= 1'b0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            tmo_q   <= tmo_d;
            rw_q    <= rw_d;
            sel_q   <= sel_d;
            tflag_q <= tflag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        tmo_d   = tmo_q;
        rw_d    = rw_q;
        sel_d   = sel_q;
        tflag_d = tflag_q;
        unique case (state_q)
            IDLE: if (start && !AS_n) begin
                state_d = SETUP;
                ph_d    = PH_SETUP;
                rw_d    = RW;
                sel_d   = cs_sel;
            end
            SETUP: begin
                if (AS_n) begin
                    state_d = RECOVER;
                    ph_d    = PH_REC;
                end else if (ph_q != 4'd0) begin
                    ph_d = ph_q - 4'd1;
                end else begin
                    state_d = ACTIVE;
                    ph_d    = PH_ACT;
                end
            end
            ACTIVE: begin
                if (AS_n) begin
                    state_d = RECOVER;
                    ph_d    = PH_REC;
                end else if (ph_q != 4'd0) begin
                    ph_d = ph_q - 4'd1;
                end else if (!rdy_s) begin
                    state_d = WAIT_RDY;
                    tmo_d   = '0;
                end else begin
                    state_d = ACK;
                end
            end
            WAIT_RDY: begin
`ifdef IDE_IORDY_EN
                // Abort wins over ready, and ready wins over the timeout on the same edge.
                if (AS_n) begin
                    state_d = RECOVER;
                    ph_d    = PH_REC;
                end else if (rdy_s) begin
                    state_d = ACK;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ACK;
                    tflag_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`else
                state_d = RECOVER;
                ph_d    = PH_REC;
`endif
            end
            ACK: if (AS_n) begin
                state_d = RECOVER;
                ph_d    = PH_REC;
            end
            RECOVER: begin
                if (ph_q != 4'd0) ph_d = ph_q - 4'd1;
                else              state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from the state register so a reset edge drops them all at once.
    assign cs_on    = (state_q == SETUP) || (state_q == ACTIVE) || (state_q == WAIT_RDY) || (state_q == ACK);
    assign stb_on   = (state_q == ACTIVE) || (state_q == WAIT_RDY);
    assign IOR_n    = !(stb_on && rw_q);
    assign IOW_n    = !(stb_on && !rw_q);
    assign IDECS1_n = !(cs_on && !sel_q);
    assign IDECS2_n = !(cs_on && sel_q);
    assign dtack    = (state_q == ACK);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ide_pio_seq.sv
// Scoreboard bench for ide_pio_seq: per-transaction timing records predicted at issue, compared at busy fall.
module tb_ide_pio_seq;
    localparam int TS = 2, TA = 9, TR = 3, RT = 64;
    localparam int STUCK = 9999;

    logic CLK = 1'b0, RESET = 1'b1, start = 1'b0, cs_sel = 1'b0, RW = 1'b0, AS_n = 1'b1, IORDY = 1'b1;
    logic IOR_n, IOW_n, IDECS1_n, IDECS2_n, dtack, busy, rdy_timeout;

    ide_pio_seq #(.T_SETUP(TS), .T_ACTIVE(TA), .T_RECOVER(TR), .RDY_TIMEOUT(RT)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .cs_sel(cs_sel), .RW(RW), .AS_n(AS_n), .IORDY(IORDY),
        .IOR_n(IOR_n), .IOW_n(IOW_n), .IDECS1_n(IDECS1_n), .IDECS2_n(IDECS2_n),
        .dtack(dtack), .busy(busy), .rdy_timeout(rdy_timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int dtack_at, stb_first, stb_len, stb_kind, cs_kind, rec_len, tmo;
    } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;
    int tmo_exp = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: measures each busy window (cycle 1 = negedge after the start-sampling edge).
    int m_cyc, m_sf, m_sl, m_sk, m_ck, m_da, m_rl;
    bit m_act = 0, m_pb = 0;
    always @(negedge CLK) begin
        if (RESET) begin
            m_act = 0;
            m_pb  = 0;
        end else begin
            if (busy) begin
                if (!m_act) begin
                    m_act = 1; m_cyc = 1; m_sf = 0; m_sl = 0; m_sk = 0; m_ck = 0; m_da = 0; m_rl = 0;
                end else m_cyc++;
                if (!IOR_n || !IOW_n) begin
                    if (m_sf == 0) m_sf = m_cyc;
                    m_sl++;
                end
                if (!IOR_n) m_sk |= 1;
                if (!IOW_n) m_sk |= 2;
                if (!IOR_n && !IOW_n) m_sk |= 4;
                if (!IDECS1_n) m_ck |= 1;
                if (!IDECS2_n) m_ck |= 2;
                if (dtack && m_da == 0) m_da = m_cyc;
                if (IDECS1_n && IDECS2_n) m_rl++;
            end else if (m_pb) begin
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("dtack_at", m_da, e.dtack_at);
                    chk("stb_first", m_sf, e.stb_first);
                    chk("stb_len", m_sl, e.stb_len);
                    chk("stb_kind", m_sk, e.stb_kind);
                    chk("cs_kind", m_ck, e.cs_kind);
                    chk("rec_len", m_rl, e.rec_len);
                    chk("rdy_timeout", int'(rdy_timeout), e.tmo);
                end
                m_act = 0;
            end
            m_pb = busy;
        end
    end

    // rise_at: 0 = IORDY high throughout; N = low from start, raised after edge N; STUCK = never raised.
    task automatic run_cyc(input bit rw, input bit sel, input int as_hold, input int abort_at,
                           input int rise_at, input int rst_at);
        exp_t e;
        int d, k, dk;
        bit rel, done;
        e.cs_kind = sel ? 2 : 1;
        e.rec_len = TR;
        if (abort_at > 0) begin
            e.dtack_at  = 0;
            e.stb_len   = (abort_at > TS) ? abort_at - TS : 0;
            e.stb_first = (e.stb_len > 0) ? TS + 1 : 0;
            e.stb_kind  = (e.stb_len > 0) ? (rw ? 1 : 2) : 0;
        end else begin
            d = TS + TA + 1;
`ifdef IDE_IORDY_EN
            if (rise_at > 0 && rise_at + 3 > d) begin
                if (rise_at + 3 > d + RT) begin
                    d = d + RT;
                    tmo_exp = 1;
                end else d = rise_at + 3;
            end
`endif
            e.dtack_at  = d;
            e.stb_first = TS + 1;
            e.stb_len   = d - (TS + 1);
            e.stb_kind  = rw ? 1 : 2;
        end
        e.tmo = tmo_exp;
        if (rst_at == 0) sb.push_back(e);

        @(posedge CLK); #1;
        start = 1'b1; AS_n = 1'b0; RW = rw; cs_sel = sel; IORDY = (rise_at == 0);
        k = 0; dk = 0; rel = 0; done = 0;
        while (!done) begin
            @(posedge CLK); #1;
            k++;
            if (rise_at > 0 && k == rise_at) IORDY = 1'b1;
            if (RESET) begin
                chk("rst_outs", int'({IOR_n, IOW_n, IDECS1_n, IDECS2_n, dtack, busy, rdy_timeout}), 'b1111000);
                start = 1'b0; AS_n = 1'b1; IORDY = 1'b1;
                tmo_exp = 0;
                @(negedge CLK); #1;
                RESET = 1'b0;
                done = 1;
            end else if (rst_at > 0 && k == rst_at) begin
                chk("pre_rst_stb", int'(rw ? IOR_n : IOW_n), 0);
                RESET = 1'b1;
            end else begin
                if (abort_at > 0 && k == abort_at && !rel) begin
                    AS_n = 1'b1; start = 1'b0; rel = 1;
                end
                if (dtack && dk == 0) dk = k;
                if (dk > 0 && !rel && k >= dk + as_hold - 1) begin
                    AS_n = 1'b1; start = 1'b0; rel = 1;
                end
                if (rel && !busy) done = 1;
            end
            if (!done && k > 300) begin
                chk("cycle_bound", k, 0);
                start = 1'b0; AS_n = 1'b1; RESET = 1'b0; IORDY = 1'b1;
                done = 1;
            end
        end
        IORDY = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_state", int'({IOR_n, IOW_n, IDECS1_n, IDECS2_n, dtack, busy, rdy_timeout}), 'b1111000);
        RESET = 1'b0;
        @(posedge CLK); #1;
        chk("idle_busy", int'(busy), 0);

        run_cyc(1, 0, 1, 0, 0, 0);        // nominal read, command block
        run_cyc(0, 1, 3, 0, 0, 0);        // write, control block, slow AS_n release
        run_cyc(1, 1, 1, 0, 19, 0);       // IORDY extension (ignored without IORDY_EN)
        run_cyc(1, 0, 1, 0, 10, 0);       // IORDY just misses the ACTIVE decision
        run_cyc(0, 0, 2, 0, STUCK, 0);    // IORDY stuck low
        run_cyc(1, 0, 1, 0, 0, 0);        // timeout flag is sticky
        run_cyc(1, 0, 1, 6, 0, 0);        // abort in ACTIVE cycle 4
        run_cyc(0, 1, 1, 1, 0, 0);        // abort in SETUP, strobe never fires
`ifdef IDE_IORDY_EN
        run_cyc(1, 0, 1, 0, STUCK, 30);   // reset while in WAIT_RDY
`else
        run_cyc(1, 0, 1, 0, 0, 8);        // reset while strobe active
`endif
        run_cyc(1, 0, 1, 0, 0, 0);        // full nominal cycle after reset
        for (int i = 0; i < 4; i++)
            run_cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), 0, 0, 0);

        repeat (3) @(posedge CLK);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
